// File: rtl/fp_pkg.sv
// Shared types for the FP writeback path: queued destination descriptor and
// fflags bit positions within the 5-bit IEEE status vector.
package fp_pkg;

    typedef struct packed {
        logic [4:0] rd;
        logic       is_int;
    } wb_entry_t;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    function automatic logic entry_match(input wb_entry_t e,
                                         input logic [4:0] rd,
                                         input logic       is_int);
        return (e.rd == rd) && (e.is_int == is_int);
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// In-order circular queue of pending FPU destinations. Exposes every slot plus
// a per-slot valid vector so the controller can scan for in-flight hazards.
module fp_wb_fifo
    import fp_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  wb_entry_t               push_entry_i,
    output wb_entry_t               pop_entry_o,
    output logic [CNT_W-1:0]        count_o,
    output wb_entry_t [DEPTH-1:0]   entries_o,
    output logic [DEPTH-1:0]        valid_o
);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      offset [DEPTH];

    // Callers guarantee push only when not full and pop only when not empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_d = count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset[i]  = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = {1'b0, offset[i]} < count_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign pop_entry_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign entries_o   = mem_q;

endmodule

// File: rtl/fp_wb_ctrl.sv
// Writeback/completion controller behind the FPU: pairs results with queued
// destinations, drives a registered RF write, and tracks fflags and hazards.
module fp_wb_ctrl
    import fp_pkg::*;
#(
    parameter int  DEPTH  = 2,
    parameter int  DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic [4:0]        issue_rd_i,
    input  logic              issue_int_i,
    output logic              issue_ready_o,
    input  logic              fpu_out_valid_i,
    input  logic [DATA_W-1:0] fpu_result_i,
    input  logic [4:0]        fpu_status_i,
    input  logic              flush_i,
    input  logic              fflags_clr_i,
    input  logic [4:0]        hazard_rd_i,
    input  logic              hazard_int_i,
    output logic              hazard_o,
    output logic              fpr_we_o,
    output logic [4:0]        fpr_waddr_o,
    output logic [DATA_W-1:0] fpr_wdata_o,
    output logic              gpr_we_o,
    output logic [4:0]        gpr_waddr_o,
    output logic [DATA_W-1:0] gpr_wdata_o,
    output logic [4:0]        fflags_o,
    output logic [CNT_W-1:0]  pending_o,
    output logic              orphan_err_o
);

    logic                  push, pop, commit, hazard;
    logic [CNT_W-1:0]      count;
    wb_entry_t             push_entry, pop_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_valid;

    logic                  wb_valid_q, wb_valid_d;
    wb_entry_t             wb_entry_q, wb_entry_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [4:0]            fflags_q, fflags_d;
    logic                  orphan_q, orphan_d;

    assign issue_ready_o = count < CNT_W'(DEPTH);
    assign push          = issue_valid_i & issue_ready_o;
    assign pop           = fpu_out_valid_i & (count != '0);
    // A pop that coincides with a flush is dropped along with the queue.
    assign commit        = pop & ~flush_i;
    assign push_entry    = '{rd: issue_rd_i, is_int: issue_int_i};

    fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (flush_i),
        .push_entry_i (push_entry),
        .pop_entry_o  (pop_entry),
        .count_o      (count),
        .entries_o    (entries),
        .valid_o      (entry_valid)
    );

    always_comb begin
        wb_valid_d = commit;
        wb_entry_d = wb_entry_q;
        wb_data_d  = wb_data_q;
        if (commit) begin
            wb_entry_d = pop_entry;
            wb_data_d  = fpu_result_i;
        end
        fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
        if (commit) begin
            fflags_d = fflags_d | fpu_status_i;
        end
        orphan_d = orphan_q | (fpu_out_valid_i & (count == '0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            wb_entry_q <= '0;
            wb_data_q  <= '0;
            fflags_q   <= '0;
            orphan_q   <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_entry_q <= wb_entry_d;
            wb_data_q  <= wb_data_d;
            fflags_q   <= fflags_d;
            orphan_q   <= orphan_d;
        end
    end

    always_comb begin
        hazard = wb_valid_q && entry_match(wb_entry_q, hazard_rd_i, hazard_int_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_match(entries[i], hazard_rd_i, hazard_int_i)) begin
                hazard = 1'b1;
            end
        end
    end

    assign hazard_o     = hazard;
    assign fpr_we_o     = wb_valid_q & ~wb_entry_q.is_int;
    assign gpr_we_o     = wb_valid_q &  wb_entry_q.is_int;
    assign fpr_waddr_o  = wb_entry_q.rd;
    assign gpr_waddr_o  = wb_entry_q.rd;
    assign fpr_wdata_o  = wb_data_q;
    assign gpr_wdata_o  = wb_data_q;
    assign fflags_o     = fflags_q;
    assign pending_o    = count;
    assign orphan_err_o = orphan_q;

endmodule

// File: tb/tb_fp_wb_ctrl.sv
// Scoreboard bench for fp_wb_ctrl: a queue-based reference model predicts each
// cycle's registered outputs; a monitor compares them one cycle later.
module tb_fp_wb_ctrl;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              issue_valid_i = 1'b0;
    logic [4:0]        issue_rd_i = '0;
    logic              issue_int_i = 1'b0;
    logic              issue_ready_o;
    logic              fpu_out_valid_i = 1'b0;
    logic [DATA_W-1:0] fpu_result_i = '0;
    logic [4:0]        fpu_status_i = '0;
    logic              flush_i = 1'b0;
    logic              fflags_clr_i = 1'b0;
    logic [4:0]        hazard_rd_i = '0;
    logic              hazard_int_i = 1'b0;
    logic              hazard_o;
    logic              fpr_we_o, gpr_we_o;
    logic [4:0]        fpr_waddr_o, gpr_waddr_o;
    logic [DATA_W-1:0] fpr_wdata_o, gpr_wdata_o;
    logic [4:0]        fflags_o;
    logic [CNT_W-1:0]  pending_o;
    logic              orphan_err_o;

    typedef struct {
        bit          we;
        bit          is_int;
        int          rd;
        logic [31:0] data;
        logic [4:0]  flags;
        int          pending;
        bit          orphan;
    } exp_t;

    typedef struct {
        int rd;
        bit is_int;
    } pend_t;

    exp_t       exp_q[$];
    pend_t      model_q[$];
    logic [4:0] model_flags = '0;
    bit         model_orphan = 0;
    bit         last_we = 0;
    int         last_rd = 0;
    bit         last_int = 0;
    bit         mon_en = 0;
    int         errors = 0;
    int         checks = 0;

    fp_wb_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_i      (issue_rd_i),
        .issue_int_i     (issue_int_i),
        .issue_ready_o   (issue_ready_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .flush_i         (flush_i),
        .fflags_clr_i    (fflags_clr_i),
        .hazard_rd_i     (hazard_rd_i),
        .hazard_int_i    (hazard_int_i),
        .hazard_o        (hazard_o),
        .fpr_we_o        (fpr_we_o),
        .fpr_waddr_o     (fpr_waddr_o),
        .fpr_wdata_o     (fpr_wdata_o),
        .gpr_we_o        (gpr_we_o),
        .gpr_waddr_o     (gpr_waddr_o),
        .gpr_wdata_o     (gpr_wdata_o),
        .fflags_o        (fflags_o),
        .pending_o       (pending_o),
        .orphan_err_o    (orphan_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Each cycle's prediction is compared just after the edge that registers it.
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("fpr_we", 32'(fpr_we_o), 32'(e.we && !e.is_int));
            checkOutput("gpr_we", 32'(gpr_we_o), 32'(e.we && e.is_int));
            if (e.we && e.is_int) begin
                checkOutput("gpr_waddr", 32'(gpr_waddr_o), 32'(e.rd));
                checkOutput("gpr_wdata", gpr_wdata_o, e.data);
            end else if (e.we) begin
                checkOutput("fpr_waddr", 32'(fpr_waddr_o), 32'(e.rd));
                checkOutput("fpr_wdata", fpr_wdata_o, e.data);
            end
            checkOutput("fflags", 32'(fflags_o), 32'(e.flags));
            checkOutput("pending", 32'(pending_o), 32'(e.pending));
            checkOutput("orphan_err", 32'(orphan_err_o), 32'(e.orphan));
        end
    end

    task automatic applyStimulus(input bit iv, input int rd, input bit isint,
                                 input bit ov, input logic [31:0] res, input logic [4:0] st,
                                 input bit fl, input bit clr, input int hrd, input bit hint);
        bit    exp_ready;
        bit    hz;
        exp_t  e;
        pend_t p;
        @(negedge clk_i);
        issue_valid_i   = iv;
        issue_rd_i      = 5'(rd);
        issue_int_i     = isint;
        fpu_out_valid_i = ov;
        fpu_result_i    = res;
        fpu_status_i    = st;
        flush_i         = fl;
        fflags_clr_i    = clr;
        hazard_rd_i     = 5'(hrd);
        hazard_int_i    = hint;
        #1;
        exp_ready = model_q.size() < DEPTH;
        hz = last_we && (last_rd == hrd) && (last_int == hint);
        foreach (model_q[i]) begin
            if (model_q[i].rd == hrd && model_q[i].is_int == hint) hz = 1;
        end
        checkOutput("issue_ready", 32'(issue_ready_o), 32'(exp_ready));
        checkOutput("hazard", 32'(hazard_o), 32'(hz));

        e.we = 0; e.is_int = 0; e.rd = 0; e.data = '0;
        if (ov && model_q.size() == 0) model_orphan = 1;
        if (clr) model_flags = '0;
        if (fl) begin
            model_q.delete();
        end else begin
            if (ov && model_q.size() > 0) begin
                p = model_q.pop_front();
                e.we = 1; e.rd = p.rd; e.is_int = p.is_int; e.data = res;
                model_flags = model_flags | st;
            end
            if (iv && exp_ready) begin
                p.rd = rd; p.is_int = isint;
                model_q.push_back(p);
            end
        end
        e.flags = model_flags;
        e.pending = model_q.size();
        e.orphan = model_orphan;
        last_we = e.we; last_rd = e.rd; last_int = e.is_int;
        exp_q.push_back(e);
        mon_en = 1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, 0);
    endtask

    // Reset is raised between edges so its asynchronous effect is visible at once.
    task automatic doReset();
        @(negedge clk_i);
        mon_en = 0;
        exp_q.delete();
        issue_valid_i = 0; fpu_out_valid_i = 0; flush_i = 0; fflags_clr_i = 0;
        hazard_rd_i = '0; hazard_int_i = 0;
        rst_i = 1;
        #1;
        checkOutput("rst_issue_ready", 32'(issue_ready_o), 32'd1);
        checkOutput("rst_fpr_we", 32'(fpr_we_o), 32'd0);
        checkOutput("rst_gpr_we", 32'(gpr_we_o), 32'd0);
        checkOutput("rst_fpr_waddr", 32'(fpr_waddr_o), 32'd0);
        checkOutput("rst_gpr_wdata", gpr_wdata_o, 32'd0);
        checkOutput("rst_fflags", 32'(fflags_o), 32'd0);
        checkOutput("rst_pending", 32'(pending_o), 32'd0);
        checkOutput("rst_orphan", 32'(orphan_err_o), 32'd0);
        checkOutput("rst_hazard", 32'(hazard_o), 32'd0);
        model_q.delete();
        model_flags = '0; model_orphan = 0; last_we = 0; last_rd = 0; last_int = 0;
        @(negedge clk_i);
        rst_i = 0;
    endtask

    initial begin
        bit          r_iv, r_int, r_ov, r_fl, r_clr, r_hint;
        int          r_rd, r_hrd;
        logic [31:0] r_res;
        logic [4:0]  r_st;

        doReset();

        // single FP op, result three cycles later
        applyStimulus(1, 5, 0, 0, '0, '0, 0, 0, 0, 0);
        idle(); idle();
        applyStimulus(0, 0, 0, 1, 32'h3F800000, 5'b00001, 0, 0, 5, 0);
        idle();

        // fill to depth; third issue must be refused
        applyStimulus(1, 1, 0, 0, '0, '0, 0, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, '0, '0, 0, 0, 1, 0);
        applyStimulus(1, 3, 0, 0, '0, '0, 0, 0, 3, 0);
        applyStimulus(0, 0, 0, 1, 32'h11111111, '0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h22222222, '0, 0, 0, 2, 0);
        idle();

        // simultaneous push/pop at count 1
        applyStimulus(1, 3, 0, 0, '0, '0, 0, 0, 0, 0);
        applyStimulus(1, 7, 1, 1, 32'hCAFE0003, '0, 0, 0, 7, 1);
        applyStimulus(0, 0, 0, 1, 32'hCAFE0007, '0, 0, 0, 7, 1);
        idle();

        // flush coinciding with a result
        applyStimulus(1, 4, 0, 0, '0, '0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'hDEADBEEF, 5'b11110, 1, 0, 4, 0);
        idle();

        // sticky flags, then clear with simultaneous status
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 1, 0, 0);
        applyStimulus(1, 10, 0, 0, '0, '0, 0, 0, 0, 0);
        applyStimulus(1, 11, 1, 1, 32'h1, 5'b10000, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h2, 5'b00100, 0, 0, 0, 0);
        applyStimulus(1, 12, 0, 0, '0, '0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h3, 5'b00001, 0, 1, 0, 0);
        idle();

        // hazard on pending and writeback-stage destination, then orphan
        applyStimulus(1, 9, 0, 0, '0, '0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 9, 1);
        applyStimulus(0, 0, 0, 1, 32'h99, '0, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 9, 0);
        applyStimulus(0, 0, 0, 1, 32'h55, 5'b01000, 0, 0, 0, 0);
        idle();

        // reset with work in flight
        applyStimulus(1, 6, 1, 0, '0, '0, 0, 0, 0, 0);
        applyStimulus(1, 8, 0, 0, '0, '0, 0, 0, 0, 0);
        doReset();

        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            r_iv   = 1'($urandom_range(0, 1));
            r_rd   = int'($urandom_range(0, 7));
            r_int  = 1'($urandom_range(0, 1));
            r_ov   = ($urandom_range(0, 9) < 4);
            r_res  = $urandom;
            r_st   = 5'($urandom_range(0, 31));
            r_fl   = ($urandom_range(0, 31) == 0);
            r_clr  = ($urandom_range(0, 19) == 0);
            r_hrd  = int'($urandom_range(0, 7));
            r_hint = 1'($urandom_range(0, 1));
            applyStimulus(r_iv, r_rd, r_int, r_ov, r_res, r_st, r_fl, r_clr, r_hrd, r_hint);
        end
        idle();
        idle();

        @(posedge clk_i);
        #2;
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
